// File: rtl/matrix_gen_ctrl.sv
// Sequencer for the k x k Kyber public matrix: per entry, XOF request -> rejection sampler -> downstream handoff.
// Define KYBER_GEN_TRANSPOSE_EN to generate A^T (swapped nonce bytes) instead of A.
module matrix_gen_ctrl #(
  parameter int K            = 3,
  parameter int SAMP_TIMEOUT = 512,
  parameter int XOF_TIMEOUT  = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [255:0]  rho,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          xof_req,
  output logic [255:0]  xof_seed,
  output logic [15:0]   xof_nonce,
  input  logic          xof_valid,
  output logic          samp_en,
  input  logic          samp_done,
  input  logic [4095:0] samp_poly,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4095:0] out_poly,
  output logic [1:0]    out_row,
  output logic [1:0]    out_col
);

  typedef enum logic [2:0] {
    S_IDLE, S_XOF_REQ, S_XOF_WAIT, S_SAMP_START, S_SAMP_WAIT, S_OUT, S_FINISH
  } state_t;

  localparam logic [1:0]  LAST_IDX  = 2'(K - 1);
  localparam logic [12:0] XOF_LIMIT  = 13'(XOF_TIMEOUT - 1);
  localparam logic [12:0] SAMP_LIMIT = 13'(SAMP_TIMEOUT - 1);

  state_t          state_reg, state_next;
  logic [255:0]    rho_reg, rho_next;
  logic [1:0]      row_reg, row_next, col_reg, col_next;
  logic [1:0]      out_row_reg, out_row_next, out_col_reg, out_col_next;
  logic [4095:0]   out_poly_reg, out_poly_next;
  logic            error_reg, error_next;
  logic [12:0]     timer_reg, timer_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      rho_reg      <= '0;
      row_reg      <= '0;
      col_reg      <= '0;
      out_row_reg  <= '0;
      out_col_reg  <= '0;
      out_poly_reg <= '0;
      error_reg    <= 1'b0;
      timer_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      rho_reg      <= rho_next;
      row_reg      <= row_next;
      col_reg      <= col_next;
      out_row_reg  <= out_row_next;
      out_col_reg  <= out_col_next;
      out_poly_reg <= out_poly_next;
      error_reg    <= error_next;
      timer_reg    <= timer_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    rho_next      = rho_reg;
    row_next      = row_reg;
    col_next      = col_reg;
    out_row_next  = out_row_reg;
    out_col_next  = out_col_reg;
    out_poly_next = out_poly_reg;
    error_next    = error_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          rho_next   = rho;
          row_next   = '0;
          col_next   = '0;
          error_next = 1'b0;
          state_next = S_XOF_REQ;
        end
      end
      S_XOF_REQ: state_next = S_XOF_WAIT;
      S_XOF_WAIT: begin
        if (xof_valid) begin
          state_next = S_SAMP_START;
        end else if (timer_reg == XOF_LIMIT) begin
          error_next = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_SAMP_START: state_next = S_SAMP_WAIT;
      // The sampler clears its stale done on the samp_en edge, so done is trusted from here on.
      S_SAMP_WAIT: begin
        if (samp_done) begin
          out_poly_next = samp_poly;
          out_row_next  = row_reg;
          out_col_next  = col_reg;
          state_next    = S_OUT;
        end else if (timer_reg == SAMP_LIMIT) begin
          error_next = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (col_reg == LAST_IDX) begin
            if (row_reg == LAST_IDX) begin
              state_next = S_FINISH;
            end else begin
              col_next   = '0;
              row_next   = row_reg + 2'd1;
              state_next = S_XOF_REQ;
            end
          end else begin
            col_next   = col_reg + 2'd1;
            state_next = S_XOF_REQ;
          end
        end
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase

    // Timeout counter restarts on every state change.
    timer_next = (state_next == state_reg) ? timer_reg + 13'd1 : '0;
  end

  assign busy      = (state_reg != S_IDLE) && (state_reg != S_FINISH);
  assign done      = (state_reg == S_FINISH);
  assign error     = error_reg;
  assign xof_req   = (state_reg == S_XOF_REQ) || (state_reg == S_XOF_WAIT);
  assign xof_seed  = rho_reg;
  assign samp_en   = (state_reg == S_SAMP_START);
  assign out_valid = (state_reg == S_OUT);
  assign out_poly  = out_poly_reg;
  assign out_row   = out_row_reg;
  assign out_col   = out_col_reg;

`ifdef KYBER_GEN_TRANSPOSE_EN
  assign xof_nonce = {8'(col_reg), 8'(row_reg)};
`else
  assign xof_nonce = {8'(row_reg), 8'(col_reg)};
`endif

endmodule

// File: tb/tb_matrix_gen_ctrl.sv
// Scoreboard bench for matrix_gen_ctrl with behavioural XOF and rejection-sampler responders.
module tb_matrix_gen_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [255:0]  rho;
  logic          busy, done, error, xof_req, samp_en, out_valid;
  logic [255:0]  xof_seed;
  logic [15:0]   xof_nonce;
  logic          xof_valid = 1'b0;
  logic          samp_done = 1'b0;
  logic [4095:0] samp_poly = '0;
  logic          out_ready = 1'b1;
  logic [4095:0] out_poly;
  logic [1:0]    out_row, out_col;

  matrix_gen_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .rho(rho),
    .busy(busy), .done(done), .error(error),
    .xof_req(xof_req), .xof_seed(xof_seed), .xof_nonce(xof_nonce), .xof_valid(xof_valid),
    .samp_en(samp_en), .samp_done(samp_done), .samp_poly(samp_poly),
    .out_valid(out_valid), .out_ready(out_ready), .out_poly(out_poly),
    .out_row(out_row), .out_col(out_col)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    r;
    logic [1:0]    c;
    logic [4095:0] poly;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           n_cmp = 0;
  int           n_err = 0;
  int           hs_idx = 0;
  int           stall_cnt = 0;
  logic         stall_en = 1'b0;
  logic         expect_req = 1'b0;
  int           req_idx = 0;
  logic         xof_req_d = 1'b0;
  logic [255:0] rho_exp = '0;
  int           done_cnt = 0;

  function automatic logic [15:0] exp_nonce(input int r, input int c);
`ifdef KYBER_GEN_TRANSPOSE_EN
    return {8'(c), 8'(r)};
`else
    return {8'(r), 8'(c)};
`endif
  endfunction

  function automatic logic [4095:0] make_poly(input logic [255:0] seed, input logic [15:0] nonce);
    return {16{seed}} ^ {256{nonce}};
  endfunction

  task automatic check(input string name, input logic [4095:0] act, input logic [4095:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (low 64 bits)", name, act[63:0], req[63:0]);
    end
  endtask

  // XOF responder: valid pulse 3 cycles after request rises; remembers seed/nonce for the sampler.
  int           xof_cnt = 0;
  logic [15:0]  nonce_lat = '0;
  logic [255:0] seed_lat = '0;
  always @(posedge clk) begin
    if (xof_req && !xof_valid) begin
      if (xof_cnt == 2) begin
        xof_valid <= 1'b1;
        nonce_lat <= xof_nonce;
        seed_lat  <= xof_seed;
      end
      xof_cnt <= xof_cnt + 1;
    end else begin
      xof_valid <= 1'b0;
      xof_cnt   <= 0;
    end
  end

  // Sampler: done stays high (stale) until the next samp_en, which clears it on that edge.
  int   samp_cnt = 0;
  logic samp_run = 1'b0;
  logic samp_hang = 1'b0;
  always @(posedge clk) begin
    if (samp_en) begin
      samp_done <= 1'b0;
      samp_cnt  <= 1;
      samp_run  <= 1'b1;
    end else if (samp_run && !samp_hang) begin
      if (samp_cnt == 225) begin
        samp_done <= 1'b1;
        samp_poly <= make_poly(seed_lat, nonce_lat);
        samp_run  <= 1'b0;
      end else begin
        samp_cnt <= samp_cnt + 1;
      end
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  // Request checker: nonce and seed on each new XOF request.
  always @(negedge clk) begin
    if (xof_req && !xof_req_d) begin
      check("xof_nonce", {4080'd0, xof_nonce}, {4080'd0, exp_nonce(req_idx / 3, req_idx % 3)});
      check("xof_seed", {3840'd0, xof_seed}, {3840'd0, rho_exp});
      req_idx++;
    end
    xof_req_d = xof_req;
  end

  // Output monitor: drives out_ready, pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (expect_req) begin
      check("xof_req after handshake", xof_req, 1'b1);
      expect_req = 1'b0;
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got row=%0d col=%0d required none", out_row, out_col);
        out_ready = 1'b1;
      end else if (stall_en && hs_idx == 1 && stall_cnt < 20) begin
        out_ready = 1'b0;
        stall_cnt++;
        check("stall out_row", out_row, exp_q[0].r);
        check("stall out_col", out_col, exp_q[0].c);
        check("stall out_poly", out_poly, exp_q[0].poly);
        check("stall no xof_req", xof_req, 1'b0);
      end else begin
        out_ready = 1'b1;
        mon_e = exp_q.pop_front();
        check("out_row", out_row, mon_e.r);
        check("out_col", out_col, mon_e.c);
        check("out_poly", out_poly, mon_e.poly);
        $display("txn %0d: row=%0d col=%0d poly[15:0]=%04h", hs_idx, out_row, out_col, out_poly[15:0]);
        expect_req = !(mon_e.r == 2'd2 && mon_e.c == 2'd2);
        hs_idx++;
      end
    end else begin
      if (stall_cnt > 0 && stall_cnt < 20) check("out_valid held in stall", out_valid, 1'b1);
      out_ready = 1'b1;
    end
  end

  task automatic issue_start(input logic [255:0] seed);
    rho_exp   = seed;
    req_idx   = 0;
    hs_idx    = 0;
    stall_cnt = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        exp_q.push_back('{r: 2'(r), c: 2'(c), poly: make_poly(seed, exp_nonce(r, c))});
    @(posedge clk); #1;
    rho   = seed;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rho   = ~seed;
  endtask

  task automatic wait_end(input int budget, output logic got_done, output logic got_err);
    got_done = 1'b0;
    got_err  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin got_done = 1'b1; break; end
      if (error) begin got_err = 1'b1; break; end
    end
    if (!got_done && !got_err) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_end: got no done/error required one within %0d cycles", budget);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " done"}, done, 1'b0);
    check({tag, " error"}, error, 1'b0);
    check({tag, " xof_req"}, xof_req, 1'b0);
    check({tag, " samp_en"}, samp_en, 1'b0);
    check({tag, " out_valid"}, out_valid, 1'b0);
    check({tag, " out_poly"}, out_poly, '0);
    check({tag, " out_row"}, out_row, 2'd0);
    check({tag, " out_col"}, out_col, 2'd0);
    check({tag, " xof_nonce"}, xof_nonce, 16'd0);
  endtask

  task automatic run_checks(input string tag, input int done_base, input logic got_done, input logic got_err);
    check({tag, " done seen"}, got_done, 1'b1);
    check({tag, " no error"}, got_err, 1'b0);
    repeat (5) @(negedge clk);
    check({tag, " busy low"}, busy, 1'b0);
    check({tag, " one done pulse"}, 32'(done_cnt - done_base), 32'd1);
    check({tag, " entries"}, 32'(hs_idx), 32'd9);
    check({tag, " queue empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    logic got_done, got_err;
    int   base, n;
    rst   = 1'b1;
    start = 1'b0;
    rho   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Full matrix, nominal latencies.
    base = done_cnt;
    issue_start(256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0);
    @(negedge clk);
    check("t1 busy after start", busy, 1'b1);
    wait_end(5000, got_done, got_err);
    run_checks("t1", base, got_done, got_err);

    // Downstream stall on entry (0,1); sampler done is stale-high from the previous run.
    stall_en = 1'b1;
    base = done_cnt;
    issue_start(256'hdeadbeef_cafef00d_11223344_55667788_99aabbcc_ddeeff00_13579bdf_2468ace0);
    wait_end(5000, got_done, got_err);
    check("t3 stall length", 32'(stall_cnt), 32'd20);
    run_checks("t3", base, got_done, got_err);
    stall_en = 1'b0;

    // Sampler never completes.
    samp_hang = 1'b1;
    base = done_cnt;
    issue_start(256'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3_00ff00ff_ff00ff00_0badf00d_f00dbabe);
    n = 0;
    while (!samp_en && n < 100) begin @(negedge clk); n++; end
    check("t5 samp_en seen", samp_en, 1'b1);
    n = 0;
    while (!error && n < 700) begin @(negedge clk); n++; end
    check("t5 timeout cycles", 32'(n), 32'd513);
    check("t5 error", error, 1'b1);
    check("t5 busy", busy, 1'b0);
    check("t5 xof_req", xof_req, 1'b0);
    check("t5 out_valid", out_valid, 1'b0);
    repeat (5) @(negedge clk);
    check("t5 error sticky", error, 1'b1);
    check("t5 no done", 32'(done_cnt - base), 32'd0);
    exp_q.delete();
    samp_hang = 1'b0;
    base = done_cnt;
    issue_start(256'h0f0f0f0f_1e1e1e1e_2d2d2d2d_3c3c3c3c_4b4b4b4b_5a5a5a5a_69696969_78787878);
    check("t5 error cleared", error, 1'b0);
    wait_end(5000, got_done, got_err);
    run_checks("t5 restart", base, got_done, got_err);

    // Start while busy is ignored; reset in SAMP_WAIT of entry 4.
    issue_start(256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888);
    repeat (4) @(posedge clk);
    #1;
    rho   = 256'hffffffff_eeeeeeee_dddddddd_cccccccc_bbbbbbbb_aaaaaaaa_99999999_00000000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (hs_idx < 4 && n < 3000) begin @(negedge clk); n++; end
    while (!samp_en && n < 3100) begin @(negedge clk); n++; end
    check("t6 reached entry 4", 32'(hs_idx), 32'd4);
    repeat (10) @(negedge clk);
    base = done_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset("t6 after rst");
    check("t6 no done on rst", 32'(done_cnt - base), 32'd0);
    base = done_cnt;
    issue_start(256'h99999999_88888888_77777777_66666666_55555555_44444444_33333333_22222222);
    wait_end(5000, got_done, got_err);
    run_checks("t6 restart", base, got_done, got_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
